gpu_mem_responder: RTL and testbench
====================================

# gpu_mem_responder

Multi-channel memory responder that serves the GPU's channelised valid/ready memory protocol (`*_mem_read_valid/address/ready/data`, `*_mem_write_valid/address/data/ready`) from an internal single-port storage array.
- Used as the simulation and FPGA backing store for instruction or data memory, in place of the external BRAM path.
- Arbitrates all channels onto the one storage port round-robin, one access per cycle.
- Returns each response after a fixed, parameterised latency.

## Interface
Parameters:
- `NUM_CHANNELS`, 8: request channels.
- `ADDR_WIDTH`, 8: word address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 16: word width.
- `LATENCY`, 2: grant-to-ready cycles; legal range ≥1.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `read_valid`, in, NUM_CHANNELS: per-channel read request.
- `read_address`, in, ADDR_WIDTH × [NUM_CHANNELS]: read word address.
- `read_ready`, out, NUM_CHANNELS: one-cycle read-response pulse.
- `read_data`, out, DATA_WIDTH × [NUM_CHANNELS]: read word; valid while `read_ready[i]` is high, then held.
- `write_valid`, in, NUM_CHANNELS: per-channel write request.
- `write_address`, in, ADDR_WIDTH × [NUM_CHANNELS]: write word address.
- `write_data`, in, DATA_WIDTH × [NUM_CHANNELS]: write word.
- `write_ready`, out, NUM_CHANNELS: one-cycle write-acknowledge pulse.

## Operation
Reset state:
- `read_ready` = 0, `write_ready` = 0, `read_data` = 0.
- Pipeline empty; round-robin pointer = 0; all `busy`/`done` flags clear.
- Storage contents are not reset.

Channel eligibility:
- Channel i is eligible when `(read_valid[i] | write_valid[i]) & ~busy[i] & ~done[i]`.
- If both valids are high on one channel (protocol violation), the read is served and the write stays pending.

Arbitration:
- Each edge, grant the first eligible channel searching upward from the pointer, wrapping at NUM_CHANNELS-1 → 0.
- Pointer becomes grant+1 (mod NUM_CHANNELS).
- No grant means the pointer is unchanged.

Access at the grant edge:
- Write: storage updated at that edge.
- Read: storage read at that edge; a read granted after a write to the same address returns the new data.

Response pipeline:
- LATENCY-deep shift register carrying {valid, channel, is_write, data}.
- At exit it pulses `read_ready[ch]` and loads `read_data[ch]`, or pulses `write_ready[ch]`.

Lockout:
- `busy[i]` is set at grant and cleared when the response pulses; at that moment `done[i]` is set.
- `done[i]` clears at the first edge where both valids of channel i are sampled low.
- Result: a requester holding valid after its ready pulse is never served twice.

Reset mid-operation:
- Pipeline flushed; in-flight responses are dropped with no ready pulse; a write already granted stays committed.
- A valid still held after reset release is treated as a fresh request.

## Timing
- Valid sampled high at edge E0 with channel granted → ready high for exactly the cycle after edge E0+LATENCY-1.
- Minimum valid-to-ready is LATENCY cycles.
- Throughput: one grant per cycle, fully pipelined. Multiple channels may see ready in consecutive cycles, never two in the same cycle.
- Worst-case wait for an eligible channel before grant: NUM_CHANNELS-1 cycles.
- `read_data[i]` holds its last value until channel i's next read response.
- All outputs are registered; there is no combinational input→output path.

## Configuration
Macro `GPU_MEM_RESP_HOST_PORT_EN`.

With the macro defined, extra ports are added:
- `host_en` (in, 1), `host_we` (in, 1), `host_addr` (in, ADDR_WIDTH), `host_wdata` (in, DATA_WIDTH), `host_rdata` (out, DATA_WIDTH, reset 0).
- `host_en` takes the storage port that cycle; the arbiter makes no grant and the pointer is frozen.
- `host_rdata` is valid the cycle after the `host_en` edge.

Without the macro these ports are absent and the arbiter owns the storage port every cycle.

## Test plan
- **Single read:** preload 0x1234 at addr 5; ch3 reads addr 5, LATENCY=2 → `read_ready[3]` pulses once, 2 cycles after the grant edge, `read_data[3]`=0x1234; other readies stay 0.
- **Write then read:** ch0 writes 0xBEEF to addr 7 → `write_ready[0]` pulses; ch1 reads addr 7 on the next cycle → 0xBEEF.
- **All-channel contention:** all 8 channels raise reads on the same cycle, pointer 0 → grants to ch0..ch7 on consecutive edges; readies on 8 consecutive cycles in order 0..7.
- **Round-robin wrap and lockout:** last grant ch6, requesters ch2 and ch7 → ch7 is granted before ch2. A requester holding valid 3 cycles past its ready gets no second ready; dropping and re-raising valid yields a new response.
- **Reset mid-flight:** reset asserted while 2 reads are in the pipeline → no ready pulses, all outputs 0; requests still held after release are each answered once.
- **Host port (macro on):** `host_en` with `host_we`=1 writes 0x00AA to addr 9 while ch0 is requesting → ch0's grant is delayed one cycle, and ch0 then reads 0x00AA.

Source files
------------

// File: rtl/gpu_mem_responder_if.sv
// Channelised GPU memory request/response bundle shared by the requesters
// (master) and the memory responder (slave).
interface gpu_mem_responder_if #(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16
);
    // Handshake: a channel raises read_valid or write_valid with its address
    // (and write_data) and holds them stable until the matching one-cycle
    // read_ready / write_ready pulse. It must then drop both valids for at
    // least one edge before it issues another request. read_data[i] is valid
    // while read_ready[i] is high and is held until that channel's next read.
    logic [NUM_CHANNELS-1:0]                 read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] read_address;
    logic [NUM_CHANNELS-1:0]                 read_ready;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] read_data;
    logic [NUM_CHANNELS-1:0]                 write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] write_address;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] write_data;
    logic [NUM_CHANNELS-1:0]                 write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/gpu_mem_responder.sv
// Round-robin multi-channel memory responder with a fixed-latency response
// pipeline. Optional host storage port: define GPU_MEM_RESP_HOST_PORT_EN.
module gpu_mem_responder #(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int LATENCY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef GPU_MEM_RESP_HOST_PORT_EN
    input  logic                  host_en,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
`endif
    gpu_mem_responder_if.slave    bus
);
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [CW-1:0]         ch;
        logic                  is_write;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]           ptr_q, ptr_d;
    logic [NUM_CHANNELS-1:0] busy_q, busy_d;
    logic [NUM_CHANNELS-1:0] done_q, done_d;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [CW-1:0]           cand;
    logic                    grant_vld;
    logic [CW-1:0]           grant_ch;
    logic                    host_busy;
    resp_t                   new_e, exit_e;

    logic [NUM_CHANNELS-1:0]                 read_ready_q, read_ready_d;
    logic [NUM_CHANNELS-1:0]                 write_ready_q, write_ready_d;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] read_data_q, read_data_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef GPU_MEM_RESP_HOST_PORT_EN
    logic [DATA_WIDTH-1:0] host_rdata_q;

    assign host_busy  = host_en;
    assign host_rdata = host_rdata_q;
`else
    assign host_busy = 1'b0;
`endif

    // Round-robin search starting at the pointer; the host port pre-empts it.
    always_comb begin
        eligible  = (bus.read_valid | bus.write_valid) & ~busy_q & ~done_q;
        cand      = '0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int off = 0; off < NUM_CHANNELS; off++) begin
            cand = CW'((int'(ptr_q) + off) % NUM_CHANNELS);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
        if (host_busy) grant_vld = 1'b0;
        ptr_d = ptr_q;
        if (grant_vld) ptr_d = (int'(grant_ch) == NUM_CHANNELS - 1) ? '0 : grant_ch + CW'(1);
    end

    // A channel asserting both valids is served as a read.
    always_comb begin
        new_e          = '0;
        new_e.valid    = grant_vld;
        new_e.ch       = grant_ch;
        new_e.is_write = ~bus.read_valid[grant_ch] & bus.write_valid[grant_ch];
        if (!new_e.is_write) new_e.data = mem_q[bus.read_address[grant_ch]];
        mem_we    = grant_vld & new_e.is_write & ~reset;
        mem_waddr = bus.write_address[grant_ch];
        mem_wdata = bus.write_data[grant_ch];
`ifdef GPU_MEM_RESP_HOST_PORT_EN
        if (host_en) begin
            mem_we    = host_we & ~reset;
            mem_waddr = host_addr;
            mem_wdata = host_wdata;
        end
`endif
    end

    // The output registers are the last stage, so LATENCY-1 stages sit in between.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign exit_e = new_e;
        end else begin : g_pipe
            resp_t pipe_q [LATENCY-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < LATENCY - 1; k++) pipe_q[k] <= '0;
                end else begin
                    pipe_q[0] <= new_e;
                    for (int k = 1; k < LATENCY - 1; k++) pipe_q[k] <= pipe_q[k-1];
                end
            end

            assign exit_e = pipe_q[LATENCY-2];
        end
    endgenerate

    // done blocks re-service until the requester has dropped both valids once.
    always_comb begin
        busy_d        = busy_q;
        done_d        = done_q;
        read_ready_d  = '0;
        write_ready_d = '0;
        read_data_d   = read_data_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!bus.read_valid[i] && !bus.write_valid[i]) done_d[i] = 1'b0;
        end
        if (grant_vld) busy_d[grant_ch] = 1'b1;
        if (exit_e.valid) begin
            busy_d[exit_e.ch] = 1'b0;
            done_d[exit_e.ch] = 1'b1;
            if (exit_e.is_write) begin
                write_ready_d[exit_e.ch] = 1'b1;
            end else begin
                read_ready_d[exit_e.ch] = 1'b1;
                read_data_d[exit_e.ch]  = exit_e.data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            busy_q        <= '0;
            done_q        <= '0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '0;
        end else begin
            ptr_q         <= ptr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            read_data_q   <= read_data_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

`ifdef GPU_MEM_RESP_HOST_PORT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rdata_q <= '0;
        end else if (host_en) begin
            host_rdata_q <= mem_q[host_addr];
        end
    end
`endif

    assign bus.read_ready  = read_ready_q;
    assign bus.write_ready = write_ready_q;
    assign bus.read_data   = read_data_q;

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Scoreboarded bench for gpu_mem_responder: arbitration order, response
// latency, lockout, reset flush and (with the macro) the host port.
module tb_gpu_mem_responder;
    localparam int NC  = 8;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int CW  = 3;
    localparam int EW  = 1 + CW + DW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gpu_mem_responder_if #(.NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef GPU_MEM_RESP_HOST_PORT_EN
    logic          host_en;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
`endif

    gpu_mem_responder #(
        .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef GPU_MEM_RESP_HOST_PORT_EN
        .host_en    (host_en),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
`endif
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard entries: {is_write, channel, read data (0 for writes)}.
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [2**AW];
    logic [NC-1:0] auto_drop;
    int            raise_cyc [NC];
    int            first_cyc [NC];
    int            resp_cnt  [NC];

    task automatic init_inputs();
        bus.read_valid    = '0;
        bus.read_address  = '0;
        bus.write_valid   = '0;
        bus.write_address = '0;
        bus.write_data    = '0;
        auto_drop         = '0;
`ifdef GPU_MEM_RESP_HOST_PORT_EN
        host_en    = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
`endif
        for (int i = 0; i < NC; i++) begin
            raise_cyc[i] = 0;
            first_cyc[i] = -1;
            resp_cnt[i]  = 0;
        end
    endtask

    // One clock: sample responses after the edge, score them, release requesters.
    task automatic step();
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        @(posedge clk);
        #1;
        cyc++;
        if ((bus.read_ready | bus.write_ready) != '0) begin
            checks++;
            if ($countones({bus.read_ready, bus.write_ready}) != 1) begin
                failures++;
                $display("FAIL one_response_per_cycle: read_ready=%b write_ready=%b, required a single bit",
                         bus.read_ready, bus.write_ready);
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (bus.read_ready[i] || bus.write_ready[i]) begin
                got = bus.read_ready[i] ? {1'b0, CW'(i), bus.read_data[i]} : {1'b1, CW'(i), {DW{1'b0}}};
                resp_cnt[i]++;
                if (first_cyc[i] < 0) first_cyc[i] = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_response: got %h at cycle %0d, required none", got, cyc);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL scoreboard: got %h, required %h", got, exp);
                    end
                end
                if (auto_drop[i]) begin
                    bus.read_valid[i]  = 1'b0;
                    bus.write_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_read(input int ch, input int addr, input logic drop);
        bus.read_address[ch] = AW'(addr);
        bus.read_valid[ch]   = 1'b1;
        auto_drop[ch]        = drop;
        raise_cyc[ch]        = cyc;
        first_cyc[ch]        = -1;
        exp_q.push_back({1'b0, CW'(ch), model_mem[addr]});
    endtask

    task automatic do_write(input int ch, input int addr, input logic [DW-1:0] data);
        bus.write_address[ch] = AW'(addr);
        bus.write_data[ch]    = data;
        bus.write_valid[ch]   = 1'b1;
        auto_drop[ch]         = 1'b1;
        raise_cyc[ch]         = cyc;
        first_cyc[ch]         = -1;
        model_mem[addr]       = data;
        exp_q.push_back({1'b1, CW'(ch), {DW{1'b0}}});
    endtask

    // Run until every expected response has arrived, then one more edge so
    // released requesters are seen idle.
    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles, required 0",
                     exp_q.size(), max_cycles);
            exp_q.delete();
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        init_inputs();
        step();
        step();
        checks++;
        if (bus.read_ready !== '0) begin
            failures++;
            $display("FAIL reset_read_ready: got %b, required 0", bus.read_ready);
        end
        checks++;
        if (bus.write_ready !== '0) begin
            failures++;
            $display("FAIL reset_write_ready: got %b, required 0", bus.write_ready);
        end
        checks++;
        if (bus.read_data !== '0) begin
            failures++;
            $display("FAIL reset_read_data: got %h, required 0", bus.read_data);
        end
`ifdef GPU_MEM_RESP_HOST_PORT_EN
        checks++;
        if (host_rdata !== '0) begin
            failures++;
            $display("FAIL reset_host_rdata: got %h, required 0", host_rdata);
        end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        do_write(0, 5, 16'h1234);
        drain(20);
        do_read(3, 5, 1'b1);
        drain(20);
        checks++;
        if (first_cyc[3] - raise_cyc[3] != LAT) begin
            failures++;
            $display("FAIL single_read_latency: got %0d cycles, required %0d", first_cyc[3] - raise_cyc[3], LAT);
        end
        checks++;
        if (resp_cnt[3] != 1) begin
            failures++;
            $display("FAIL single_read_count: got %0d pulses, required 1", resp_cnt[3]);
        end
        checks++;
        if (bus.read_data[3] !== 16'h1234) begin
            failures++;
            $display("FAIL single_read_hold: got %h, required 1234", bus.read_data[3]);
        end
    endtask

    task automatic test_write_then_read();
        do_write(0, 7, 16'hBEEF);
        step();
        do_read(1, 7, 1'b1);
        drain(20);
        checks++;
        if (bus.read_data[1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_then_read_data: got %h, required beef", bus.read_data[1]);
        end
    endtask

    task automatic test_all_channels();
        int base;
        // Pointer is 2 here: concurrent writes are served 2..7 then 0,1.
        for (int k = 0; k < NC; k++) begin
            do_write((k + 2) % NC, 16 + ((k + 2) % NC), DW'($urandom_range(0, 16'hFFFF)));
        end
        drain(40);
        do_read(7, 16, 1'b1);
        drain(20);
        base = cyc;
        for (int i = 0; i < NC; i++) do_read(i, 16 + NC - 1 - i, 1'b1);
        drain(40);
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (first_cyc[i] != base + LAT + i) begin
                failures++;
                $display("FAIL contention_order ch%0d: ready at cycle %0d, required %0d", i, first_cyc[i], base + LAT + i);
            end
        end
    endtask

    task automatic test_rr_wrap_lockout();
        int base;
        do_read(6, 17, 1'b1);
        drain(20);
        base = cyc;
        do_read(7, 18, 1'b1);
        do_read(2, 19, 1'b1);
        drain(20);
        checks++;
        if (first_cyc[7] != base + LAT || first_cyc[2] != base + LAT + 1) begin
            failures++;
            $display("FAIL rr_wrap: ch7 at %0d ch2 at %0d, required %0d and %0d",
                     first_cyc[7], first_cyc[2], base + LAT, base + LAT + 1);
        end
        resp_cnt[4] = 0;
        do_read(4, 20, 1'b0);
        drain(20);
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (resp_cnt[4] != 1) begin
            failures++;
            $display("FAIL lockout_hold: got %0d responses, required 1", resp_cnt[4]);
        end
        bus.read_valid[4] = 1'b0;
        step();
        do_read(4, 21, 1'b1);
        drain(20);
        checks++;
        if (resp_cnt[4] != 2) begin
            failures++;
            $display("FAIL lockout_rerequest: got %0d responses, required 2", resp_cnt[4]);
        end
    endtask

    task automatic test_reset_midflight();
        do_read(0, 22, 1'b0);
        do_read(1, 23, 1'b0);
        step();
        reset = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (bus.read_ready !== '0 || bus.write_ready !== '0 || bus.read_data !== '0) begin
            failures++;
            $display("FAIL midflight_reset_outputs: rr=%b wr=%b rd=%h, required all 0",
                     bus.read_ready, bus.write_ready, bus.read_data);
        end
        step();
        step();
        checks++;
        if (bus.read_ready !== '0 || bus.write_ready !== '0) begin
            failures++;
            $display("FAIL midflight_flush: rr=%b wr=%b, required 0", bus.read_ready, bus.write_ready);
        end
        resp_cnt[0] = 0;
        resp_cnt[1] = 0;
        reset = 1'b0;
        do_read(0, 22, 1'b0);
        do_read(1, 23, 1'b0);
        drain(20);
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (resp_cnt[0] != 1 || resp_cnt[1] != 1) begin
            failures++;
            $display("FAIL midflight_reissue: ch0=%0d ch1=%0d responses, required 1 each", resp_cnt[0], resp_cnt[1]);
        end
        checks++;
        if (first_cyc[0] - raise_cyc[0] != LAT) begin
            failures++;
            $display("FAIL midflight_latency: got %0d, required %0d", first_cyc[0] - raise_cyc[0], LAT);
        end
        bus.read_valid = '0;
        step();
    endtask

`ifdef GPU_MEM_RESP_HOST_PORT_EN
    task automatic test_host_port();
        host_en         = 1'b1;
        host_we         = 1'b1;
        host_addr       = AW'(9);
        host_wdata      = 16'h00AA;
        model_mem[9]    = 16'h00AA;
        do_read(0, 9, 1'b1);
        step();
        host_en = 1'b0;
        host_we = 1'b0;
        drain(20);
        checks++;
        if (first_cyc[0] - raise_cyc[0] != LAT + 1) begin
            failures++;
            $display("FAIL host_delay: got %0d cycles, required %0d", first_cyc[0] - raise_cyc[0], LAT + 1);
        end
        host_en   = 1'b1;
        host_addr = AW'(9);
        step();
        host_en = 1'b0;
        checks++;
        if (host_rdata !== 16'h00AA) begin
            failures++;
            $display("FAIL host_read: got %h, required 00aa", host_rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_all_channels();
        test_rr_wrap_lockout();
        test_reset_midflight();
`ifdef GPU_MEM_RESP_HOST_PORT_EN
        test_host_port();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
